// File: rtl/alt_vipswi131_common_sync_filter.sv
// Multi-bit synchroniser plus stability filter. data_out only takes a value after it has been sampled STABLE_CYCLES times in a row.
// The optional glitch counter is built only when ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN is defined.
module alt_vipswi131_common_sync_filter #(
  parameter int               CLOCKS_ARE_SAME = 0,
  parameter int               WIDTH           = 1,
  parameter int               SYNC_STAGES     = 2,
  parameter int               STABLE_CYCLES   = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             rst,
  input  logic             sync_clock,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_changed,
  output logic             busy
`ifdef ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN
  ,
  output logic [15:0]      glitch_count
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

  typedef enum logic {IDLE, QUAL} state_t;

  logic [WIDTH-1:0] sync_out;

  generate
    if (CLOCKS_ARE_SAME != 0) begin : g_bypass
      assign sync_out = data_in;
    end else begin : g_sync
      (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS; -name SDC_STATEMENT {set_false_path -to [get_keepers {*g_sync.stage0*}]}" *)
      logic [WIDTH-1:0] stage0;
      (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
      logic [SYNC_STAGES-2:0][WIDTH-1:0] stages;

      // NOTE: the synchroniser array is ordinary flops, not RAM, so it is safe to reset every entry.
      always_ff @(posedge sync_clock or posedge rst) begin
        if (rst) begin
          stage0 <= RESET_VALUE;
          for (int i = 0; i < SYNC_STAGES - 1; i++) stages[i] <= RESET_VALUE;
        end else begin
          stage0    <= data_in;
          stages[0] <= stage0;
          for (int i = 1; i < SYNC_STAGES - 1; i++) stages[i] <= stages[i-1];
        end
      end

      assign sync_out = stages[SYNC_STAGES-2];
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_d;
  logic             changed_d;

  // NOTE: every sequential state update uses <= so all flops sample the pre-edge values together.
  always_ff @(posedge sync_clock or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cand_q       <= RESET_VALUE;
      count_q      <= '0;
      data_out     <= RESET_VALUE;
      data_changed <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      count_q      <= count_d;
      data_out     <= out_d;
      data_changed <= changed_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    count_d   = count_q;
    out_d     = data_out;
    changed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_out != data_out) begin
          if (STABLE_CYCLES == 1) begin
            out_d     = sync_out;
            changed_d = 1'b1;
          end else begin
            cand_d  = sync_out;
            count_d = CW'(1);
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        if (sync_out == cand_q) begin
          if (count_q == LAST_COUNT) begin
            out_d     = cand_q;
            changed_d = 1'b1;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else if (sync_out == data_out) begin
          // Input fell back to the published value: the candidate was a glitch.
          count_d = '0;
          state_d = IDLE;
        end else begin
          cand_d  = sync_out;
          count_d = CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == QUAL);
  end

`ifdef ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN
  // Any disagreement with the candidate while qualifying is either an abort or a restart.
  logic glitch_evt;
  assign glitch_evt = (state_q == QUAL) && (sync_out != cand_q);

  always_ff @(posedge sync_clock or posedge rst) begin
    if (rst) begin
      glitch_count <= '0;
    end else if (glitch_evt && (glitch_count != 16'hFFFF)) begin
      glitch_count <= glitch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alt_vipswi131_common_sync_filter.sv
// Directed bench: a qualified 2-stage/3-sample instance driven from a vector table, plus a same-clock bypass instance.
// Glitch counter checks are compiled only with ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN.
module tb_alt_vipswi131_common_sync_filter;

  typedef struct {
    logic        rst;
    logic [3:0]  din;
    logic [3:0]  out;
    logic        chg;
    logic        busy;
    logic [15:0] gc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din_a = 4'h3;
  logic [3:0] din_b = 4'h0;
  logic [3:0] out_a, out_b;
  logic       chg_a, chg_b, busy_a, busy_b;
`ifdef ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN
  logic [15:0] gc_a, gc_b;
`endif

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  alt_vipswi131_common_sync_filter #(
    .CLOCKS_ARE_SAME(0), .WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(3), .RESET_VALUE(4'h3)
  ) dut_a (
    .rst(rst), .sync_clock(clk), .data_in(din_a),
    .data_out(out_a), .data_changed(chg_a), .busy(busy_a)
`ifdef ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN
    , .glitch_count(gc_a)
`endif
  );

  alt_vipswi131_common_sync_filter #(
    .CLOCKS_ARE_SAME(1), .WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(1), .RESET_VALUE(4'h0)
  ) dut_b (
    .rst(rst), .sync_clock(clk), .data_in(din_b),
    .data_out(out_b), .data_changed(chg_b), .busy(busy_b)
`ifdef ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN
    , .glitch_count(gc_b)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] d, input logic [3:0] o,
                     input logic c, input logic b, input logic [15:0] g);
    vec_t v;
    v.rst = r; v.din = d; v.out = o; v.chg = c; v.busy = b; v.gc = g;
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: inputs applied before an edge, outputs expected just after it.
    add(1, 4'h3, 4'h3, 0, 0, 0);  // reset
    add(0, 4'h3, 4'h3, 0, 0, 0);
    add(0, 4'hA, 4'h3, 0, 0, 0);  // clean step, launch edge k
    add(0, 4'hA, 4'h3, 0, 0, 0);
    add(0, 4'hA, 4'h3, 0, 1, 0);  // k+2
    add(0, 4'hA, 4'h3, 0, 1, 0);  // k+3
    add(0, 4'hA, 4'hA, 1, 0, 0);  // k+4 update
    add(0, 4'hA, 4'hA, 0, 0, 0);
    add(0, 4'hA, 4'hA, 0, 0, 0);
    add(0, 4'h5, 4'hA, 0, 0, 0);  // two-cycle glitch
    add(0, 4'h5, 4'hA, 0, 0, 0);
    add(0, 4'hA, 4'hA, 0, 1, 0);
    add(0, 4'hA, 4'hA, 0, 1, 0);
    add(0, 4'hA, 4'hA, 0, 0, 1);  // abort
    add(0, 4'hA, 4'hA, 0, 0, 1);
    add(0, 4'h5, 4'hA, 0, 0, 1);  // bounce 5 then 6
    add(0, 4'h6, 4'hA, 0, 0, 1);  // launch edge of 6
    add(0, 4'h6, 4'hA, 0, 1, 1);
    add(0, 4'h6, 4'hA, 0, 1, 2);  // restart on 6
    add(0, 4'h6, 4'hA, 0, 1, 2);
    add(0, 4'h6, 4'h6, 1, 0, 2);  // launch+4
    add(0, 4'h6, 4'h6, 0, 0, 2);
    add(0, 4'hC, 4'h6, 0, 0, 2);  // start qualifying C
    add(0, 4'hC, 4'h6, 0, 0, 2);
    add(0, 4'hC, 4'h6, 0, 1, 2);
    add(1, 4'hC, 4'h3, 0, 0, 0);  // reset while busy
    add(0, 4'h3, 4'h3, 0, 0, 0);
    add(0, 4'h3, 4'h3, 0, 0, 0);
    add(0, 4'h3, 4'h3, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      din_a = vecs[i].din;
      @(posedge clk);
      #1;
      check($sformatf("v%0d data_out", i), 16'(out_a), 16'(vecs[i].out));
      check($sformatf("v%0d data_changed", i), 16'(chg_a), 16'(vecs[i].chg));
      check($sformatf("v%0d busy", i), 16'(busy_a), 16'(vecs[i].busy));
`ifdef ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN
      check($sformatf("v%0d glitch_count", i), gc_a, vecs[i].gc);
`endif
    end

    // Asynchronous reset mid-qualify, checked with no clock edge in between.
    din_a = 4'h9;
    repeat (3) @(posedge clk);
    #1;
    check("mq busy before reset", 16'(busy_a), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("mq async data_out", 16'(out_a), 16'h3);
    check("mq async busy", 16'(busy_a), 16'd0);
    check("mq async data_changed", 16'(chg_a), 16'd0);
    @(posedge clk);
    #1;
    din_a = 4'h3;
    rst   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("mq release %0d data_changed", i), 16'(chg_a), 16'd0);
      check($sformatf("mq release %0d data_out", i), 16'(out_a), 16'h3);
      check($sformatf("mq release %0d busy", i), 16'(busy_a), 16'd0);
    end

    // Same-clock bypass with single-sample qualification updates on the launch edge.
    check("bypass idle data_out", 16'(out_b), 16'h0);
    check("bypass idle data_changed", 16'(chg_b), 16'd0);
    din_b = 4'h9;
    @(posedge clk);
    #1;
    check("bypass edge k data_out", 16'(out_b), 16'h9);
    check("bypass edge k data_changed", 16'(chg_b), 16'd1);
    check("bypass edge k busy", 16'(busy_b), 16'd0);
    @(posedge clk);
    #1;
    check("bypass edge k+1 data_out", 16'(out_b), 16'h9);
    check("bypass edge k+1 data_changed", 16'(chg_b), 16'd0);
`ifdef ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN
    check("bypass glitch_count", gc_b, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alt_vipswi131_common_sync_filter.md
Name: alt_vipswi131_common_sync_filter

Overview:
- Parametrised successor to the common bit synchroniser: N-stage synchroniser followed by a stability (deglitch) filter.
- Outputs a multi-bit word only after it has been stable for a programmable number of `sync_clock` samples, plus a one-cycle change pulse.
- Used for quasi-static control and status buses (mode, resolution, enable) crossing into the switch's clock domain.

Parameters:
- CLOCKS_ARE_SAME, 0: 1 bypasses the synchroniser chain; the filter is retained.
- WIDTH, 1: data bus width, >=1.
- SYNC_STAGES, 2: synchroniser flops, >=2; ignored when CLOCKS_ARE_SAME=1.
- STABLE_CYCLES, 1: consecutive identical samples required before `data_out` updates, >=1.
- RESET_VALUE, 0: WIDTH-bit value loaded into all data registers on reset.

Ports:
- rst  input  1  asynchronous reset, active-high
- sync_clock  input  1  destination clock; the only clock of the block
- data_in  input  WIDTH  asynchronous (or same-clock) input word
- data_out  output  WIDTH  filtered, synchronised word
- data_changed  output  1  single-cycle pulse on the cycle `data_out` takes a new value
- busy  output  1  high while a candidate value is being qualified

Behaviour:
- Reset (async, any time): sync chain, `data_out` and candidate set to RESET_VALUE; `data_changed`=0; `busy`=0; counter=0; state=IDLE. Effect is immediate, with no pulse on release.
- Sync chain: stage0 <= data_in; stage[i] <= stage[i-1]; sync_out = stage[SYNC_STAGES-1]. With CLOCKS_ARE_SAME=1, sync_out = data_in combinationally.
- Stage0 carries the synchroniser-identification and false-path-to-stage0 attributes; the other stages carry synchroniser identification only.
- Counter width: clog2(STABLE_CYCLES)+1.
- IDLE, sync_out==data_out: no action.
- IDLE, sync_out!=data_out:
  - If STABLE_CYCLES==1: data_out<=sync_out, pulse; stay IDLE.
  - Else: candidate<=sync_out, count<=1, go QUAL.
- QUAL, sync_out==candidate:
  - If count==STABLE_CYCLES-1: data_out<=candidate, data_changed pulse, count<=0, go IDLE.
  - Else: count++.
- QUAL, sync_out!=candidate:
  - If sync_out==data_out: abort (glitch), count<=0, go IDLE.
  - Else: candidate<=sync_out, count<=1, stay QUAL (restart).
- `busy` = (state==QUAL), registered.
- `data_changed` is registered, high exactly one cycle, coincident with the `data_out` update.
- Latency: data_in changes before edge k and stays stable, so `data_out` updates at edge k+SYNC_STAGES+STABLE_CYCLES-1. With CLOCKS_ARE_SAME=1 the update is at edge k+STABLE_CYCLES-1.
- `data_out` never takes a value that was not stable for STABLE_CYCLES samples; intermediate bounce values never appear.
- Multi-bit skew through the chain is treated as instability and filtered. Skew wider than STABLE_CYCLES-1 cycles is a system constraint violation.

Optional Feature:
- Macro: ALT_VIPSWI131_SYNC_GLITCH_COUNT_EN.
- Defined:
  - Adds output `glitch_count`, 16 bits, reset 0.
  - Increments by 1 on every QUAL abort and every QUAL restart.
  - Saturates at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: WIDTH=4, RESET_VALUE=4'h3, rst pulsed mid-run -> data_out=4'h3, data_changed=0, busy=0 immediately, with no clock needed.
- Clean step: WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=3, data_in 0->4'hA before edge k and held -> data_out=4'hA at edge k+4; data_changed high only in that cycle; busy high for edges k+2..k+3.
- Glitch: data_out=4'hA, data_in=4'h5 for 2 cycles then back to 4'hA -> data_out stays 4'hA, no pulse; glitch_count=1 when the macro is defined.
- Bounce: data_out=4'hA, data_in 4'h5 for 1 cycle then 4'h6 held -> 4'h5 never appears; data_out=4'h6 at (4'h6 launch edge)+4; exactly one pulse.
- Reset mid-qualify: assert rst while busy=1 -> busy=0, data_out=RESET_VALUE, no data_changed after release.
- Bypass: CLOCKS_ARE_SAME=1, STABLE_CYCLES=1, data_in 4'h0->4'h9 before edge k -> data_out=4'h9 and data_changed=1 at edge k.
